// File: rtl/ps2_pkg.sv
// Shared constants, FSM encoding and byte-level helpers for the PS/2 keyboard receive path.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [2:0] ERR_START   = 3'd1;
    localparam logic [2:0] ERR_PARITY  = 3'd2;
    localparam logic [2:0] ERR_STOP    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    // PS/2 uses odd parity: data ones plus the parity bit must be odd.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    function automatic logic is_prefix(input logic [7:0] data);
        return (data == PS2_EXT) || (data == PS2_BRK);
    endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Synchronizes the PS/2 pins into sys_clk, debounces kb_clk and emits a one-cycle
// strobe on each filtered falling edge together with the synced data level.
module ps2_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic kb_clk,
    input  logic kb_data,
    output logic data_s,
    output logic fall
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic [CNT_W-1:0]       stable_cnt_q;
    logic                   clk_filt_q;
    logic                   clk_filt_prev_q;
    logic                   clk_s;

    // Idle bus level is high, so the chains come out of reset at 1.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], kb_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], kb_data};
        end
    end

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

    // The filtered level flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            stable_cnt_q    <= '0;
            clk_filt_q      <= 1'b1;
            clk_filt_prev_q <= 1'b1;
        end else begin
            clk_filt_prev_q <= clk_filt_q;
            if (clk_s == clk_filt_q) begin
                stable_cnt_q <= '0;
            end else if (stable_cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                stable_cnt_q <= '0;
                clk_filt_q   <= clk_s;
            end else begin
                stable_cnt_q <= stable_cnt_q + 1'b1;
            end
        end
    end

    assign fall = clk_filt_prev_q & ~clk_filt_q;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: frames 11-bit words, checks start/parity/stop,
// guards against stalled frames and folds E0/F0 prefixes into single key events.
module ps2_frame_receiver
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       kb_clk,
    input  logic       kb_data,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_release,
    output logic       key_valid,
    output logic [7:0] frame_byte,
    output logic       frame_valid,
    output logic       frame_err,
    output logic [2:0] err_type
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic            data_s;
    logic            fall;
    ps2_state_t      state_q;
    ps2_state_t      state_d;
    logic [7:0]      shift_q;
    logic [2:0]      bit_cnt_q;
    logic            parity_q;
    logic [WD_W-1:0] wd_q;
    logic            ext_pend_q;
    logic            rel_pend_q;

    logic            timeout_p0;
    logic            good_vld_p0;
    logic            err_vld_p0;
    logic [2:0]      err_code_p0;

    ps2_input_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filter (
        .sys_clk (sys_clk),
        .reset   (reset),
        .kb_clk  (kb_clk),
        .kb_data (kb_data),
        .data_s  (data_s),
        .fall    (fall)
    );

    // A fall in the same cycle always wins over the watchdog.
    assign timeout_p0 = (state_q != ST_IDLE) && !fall &&
                        (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout_p0) begin
            state_d = ST_IDLE;
        end else if (fall) begin
            case (state_q)
                ST_IDLE:   if (!data_s) state_d = ST_DATA;
                ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Stop failure outranks parity failure when both are wrong.
    always_comb begin
        good_vld_p0 = 1'b0;
        err_vld_p0  = 1'b0;
        err_code_p0 = ERR_START;
        if (timeout_p0) begin
            err_vld_p0  = 1'b1;
            err_code_p0 = ERR_TIMEOUT;
        end else if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (data_s) begin
                        err_vld_p0  = 1'b1;
                        err_code_p0 = ERR_START;
                    end
                end
                ST_STOP: begin
                    if (!data_s) begin
                        err_vld_p0  = 1'b1;
                        err_code_p0 = ERR_STOP;
                    end else if (!parity_ok(shift_q, parity_q)) begin
                        err_vld_p0  = 1'b1;
                        err_code_p0 = ERR_PARITY;
                    end else begin
                        good_vld_p0 = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
        end else if (timeout_p0) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else if (fall) begin
            case (state_q)
                ST_IDLE:   bit_cnt_q <= '0;
                ST_DATA: begin
                    shift_q   <= {data_s, shift_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                ST_PARITY: parity_q <= data_s;
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset)                        wd_q <= '0;
        else if (state_q == ST_IDLE || fall) wd_q <= '0;
        else                              wd_q <= wd_q + 1'b1;
    end

    // Stage p0 -> p1: decisions made on the deciding fall become visible one cycle later.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            key_code    <= '0;
            key_ext     <= 1'b0;
            key_release <= 1'b0;
            key_valid   <= 1'b0;
            frame_byte  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_type    <= '0;
            ext_pend_q  <= 1'b0;
            rel_pend_q  <= 1'b0;
        end else begin
            frame_valid <= good_vld_p0;
            key_valid   <= good_vld_p0 && !is_prefix(shift_q);
            frame_err   <= err_vld_p0;
            if (good_vld_p0) begin
                frame_byte <= shift_q;
                if (shift_q == PS2_EXT) begin
                    ext_pend_q <= 1'b1;
                end else if (shift_q == PS2_BRK) begin
                    rel_pend_q <= 1'b1;
                end else begin
                    key_code    <= shift_q;
                    key_ext     <= ext_pend_q;
                    key_release <= rel_pend_q;
                    ext_pend_q  <= 1'b0;
                    rel_pend_q  <= 1'b0;
                end
            end
            if (err_vld_p0) begin
                err_type   <= err_code_p0;
                ext_pend_q <= 1'b0;
                rel_pend_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Self-checking bench for ps2_frame_receiver: directed and random PS/2 frames scored
// against a frame-level reference model using expectation queues.
module tb_ps2_frame_receiver;

    localparam int SYNC = 2;
    localparam int FLEN = 4;
    localparam int TOUT = 500;
    localparam int HALF = 400;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       kb_clk  = 1'b1;
    logic       kb_data = 1'b1;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       key_valid;
    logic [7:0] frame_byte;
    logic       frame_valid;
    logic       frame_err;
    logic [2:0] err_type;

    ps2_frame_receiver #(
        .SYNC_STAGES    (SYNC),
        .FILTER_LEN     (FLEN),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .kb_clk      (kb_clk),
        .kb_data     (kb_data),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_release (key_release),
        .key_valid   (key_valid),
        .frame_byte  (frame_byte),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .err_type    (err_type)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int unsigned last_fall_cyc = 0;

    // Reference model state
    logic [7:0] fq[$];
    logic [9:0] kq[$];
    logic [2:0] errq[$];
    logic       m_ext = 1'b0, m_rel = 1'b0;
    logic [7:0] m_code = 8'h00, m_fbyte = 8'h00;
    logic       m_kext = 1'b0, m_krel = 1'b0;
    logic [2:0] m_err = 3'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_err(input logic [2:0] code);
        errq.push_back(code);
        m_err = code;
        m_ext = 1'b0;
        m_rel = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
        if (!stop_ok) model_err(3'd3);
        else if (!par_ok) model_err(3'd2);
        else begin
            fq.push_back(b);
            m_fbyte = b;
            if (b == 8'hE0) m_ext = 1'b1;
            else if (b == 8'hF0) m_rel = 1'b1;
            else begin
                kq.push_back({b, m_ext, m_rel});
                m_code = b; m_kext = m_ext; m_krel = m_rel;
                m_ext = 1'b0; m_rel = 1'b0;
            end
        end
    endtask

    task automatic check_hold();
        check_eq("hold_key_code", key_code, m_code);
        check_eq("hold_key_ext", key_ext, m_kext);
        check_eq("hold_key_release", key_release, m_krel);
        check_eq("hold_frame_byte", frame_byte, m_fbyte);
        check_eq("hold_err_type", err_type, m_err);
    endtask

    // bits[0] is sent first; data changes mid-high, device drives the clock low afterwards
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            #(HALF/2); kb_data = bits[i];
            #(HALF/2); kb_clk = 1'b0; last_fall_cyc = cyc;
            #(HALF);   kb_clk = 1'b1;
        end
        #(HALF/2); kb_data = 1'b1;
        #(HALF/2);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par, stop;
        par  = (~^b) ^ bad_par;
        stop = ~bad_stop;
        model_frame(b, !bad_par, !bad_stop);
        send_bits({stop, par, b, 1'b0}, 11);
        #200;
        check_hold();
    endtask

    // Scoreboard: every pulse must match the oldest outstanding expectation.
    always @(negedge sys_clk) begin
        if (!reset) begin
            if (frame_valid) begin
                if (fq.size() == 0) check_eq("frame_unexpected", frame_valid, 1'b0);
                else check_eq("frame_byte", frame_byte, fq.pop_front());
            end
            if (key_valid) begin
                if (kq.size() == 0) check_eq("key_unexpected", key_valid, 1'b0);
                else check_eq("key_event", {key_code, key_ext, key_release}, kq.pop_front());
            end
            if (frame_err) begin
                err_seen++;
                if (errq.size() == 0) check_eq("err_unexpected", frame_err, 1'b0);
                else check_eq("err_type", err_type, errq.pop_front());
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_outs"}, {key_code, key_ext, key_release, key_valid,
                                  frame_byte, frame_valid, frame_err, err_type}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench time limit reached, checks=%0d", n_checks);
        $fatal(1, "bench watchdog");
    end

    initial begin
        int lat;
        int e0;
        @(negedge sys_clk);
        #40;
        check_all_zero("reset");
        reset = 1'b0;
        #100;

        // 1: plain make code
        send_frame(8'h1C, 0, 0);
        // 2: break sequence then plain make
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        send_frame(8'h1C, 0, 0);
        // 3: extended break
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        // 4: parity error, then broken break sequence
        send_frame(8'h1C, 1, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h44, 0, 1);
        send_frame(8'h29, 0, 0);

        // start error: a single clock pulse with data high
        model_err(3'd1);
        send_bits(11'h001, 1);
        #200;
        check_hold();

        // 5: stalled frame after start + 5 bits
        model_err(3'd4);
        send_bits(11'b000_0101_0110, 6);
        lat = -1;
        for (int k = 0; k < TOUT + 100; k++) begin
            @(negedge sys_clk);
            if (frame_err) begin
                lat = int'(cyc - last_fall_cyc);
                break;
            end
        end
        check_eq("timeout_not_early", lat >= TOUT, 1'b1);
        check_eq("timeout_not_late", (lat >= 0) && (lat <= TOUT + SYNC + FLEN + 4), 1'b1);
        #100;
        check_hold();
        send_frame(8'h29, 0, 0);

        // 6: reset after 4 data bits; partially sent E0 must leave no trace
        send_frame(8'hE0, 0, 0);
        send_bits(11'b000_0001_1010, 5);
        reset = 1'b1;
        #30;
        check_all_zero("midframe_reset");
        m_ext = 0; m_rel = 0; m_code = 0; m_kext = 0; m_krel = 0; m_fbyte = 0; m_err = 0;
        reset = 1'b0;
        #100;
        send_frame(8'h5A, 0, 0);

        // 7: short low glitches while idle
        e0 = err_seen;
        for (int g = 0; g < 4; g++) begin
            kb_clk = 1'b0; #20;
            kb_clk = 1'b1; #200;
        end
        check_eq("glitch_no_err", err_seen, e0);
        send_frame(8'h1C, 0, 0);

        // random frames: mixture of prefixes, codes and single-fault frames
        for (int r = 0; r < 16; r++) begin
            logic [7:0] b;
            int sel, e;
            sel = $urandom_range(0, 7);
            e   = $urandom_range(0, 9);
            b   = (sel == 0) ? 8'hE0 : (sel == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
            send_frame(b, e == 0, e == 1);
            #($urandom_range(0, 20) * 10);
        end

        #1000;
        check_eq("frames_outstanding", fq.size(), 0);
        check_eq("keys_outstanding", kq.size(), 0);
        check_eq("errs_outstanding", errq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
